axis_sync_fifo: RTL and testbench
=================================

# axis_sync_fifo

Single-clock AXI4-Stream FIFO that buffers `DATA_WIDTH`-bit words between an upstream slave port and a downstream master port. It decouples producer and consumer back-pressure inside the controller datapath, for example as an input FIFO ahead of a stream consumer. Read-out is first-word-fall-through with a single cycle of write-to-read latency.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: log2 of the storage depth. Depth is `2**ADDR_WIDTH` words (16 by default).
- `DATA_WIDTH`, default 16: word width in bits.

Ports:
- `rst`  in  1: reset; one clock, asynchronous, active-high.
- `clk`  in  1: the single clock; everything is sampled on the rising edge.
- `s_axis_tvalid`  in  1: upstream word valid.
- `s_axis_tready`  out  1: FIFO can accept a word.
- `s_axis_tdata`  in  DATA_WIDTH: upstream word.
- `m_axis_tdata`  out  DATA_WIDTH: head-of-FIFO word.
- `m_axis_tvalid`  out  1: FIFO holds at least one word.
- `m_axis_tready`  in  1: downstream accepts the head word.
- `count`  out  ADDR_WIDTH+1: occupancy. Present only with `AXIS_SYNC_FIFO_COUNT_EN`.

Instantiation order is positional, in exactly the port order listed above.

## Operation
- Storage: register array of `2**ADDR_WIDTH` x `DATA_WIDTH`, plus write and read pointers of `ADDR_WIDTH+1` bits each.
  - Pointers index memory with their low `ADDR_WIDTH` bits.
  - The MSB distinguishes full from empty.
  - Pointers wrap modulo `2**(ADDR_WIDTH+1)`.
- Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Write: on the rising edge when `s_axis_tvalid && s_axis_tready`, store `s_axis_tdata` at the write pointer and increment it.
- Read: on the rising edge when `m_axis_tvalid && m_axis_tready`, increment the read pointer.
- `m_axis_tdata` = memory at the read pointer, driven combinationally from the array.
  - Its value is don't-care while `m_axis_tvalid` = 0.
  - While `m_axis_tvalid` = 1 and `m_axis_tready` = 0, `m_axis_tdata` must stay stable.
- `m_axis_tvalid` = not empty.
- `s_axis_tready` = not full, gated by the reset state (see Timing).
- Data leaves in strict arrival order. No words are dropped or duplicated.
- Simultaneous read and write in the same cycle:
  - Both take effect and occupancy is unchanged.
  - When full, `s_axis_tready` = 0, so only the read occurs. The freed slot becomes writable on the next cycle.
  - When empty, only the write occurs. The word appears on the next cycle.
- Handshake misuse:
  - Upstream asserting `s_axis_tvalid` while `s_axis_tready` = 0 has no effect. The data is not stored.
  - Downstream asserting `m_axis_tready` while `m_axis_tvalid` = 0 has no effect.

## Timing
- Reset is asynchronous and takes effect immediately. While `rst` = 1:
  - pointers = 0
  - `m_axis_tvalid` = 0
  - `s_axis_tready` = 0
  - `count` = 0
- `s_axis_tready` comes from an internal registered ready flag.
  - The flag clears asynchronously on reset.
  - It sets on the first rising edge after `rst` deasserts.
  - After that, `s_axis_tready` = flag AND not full.
- Asserting reset mid-operation discards all contents. After release the FIFO is empty.
- Write-to-read latency is 1 cycle. A word written at edge k gives `m_axis_tvalid` = 1 with that word on `m_axis_tdata` immediately after edge k.
- Full is flagged immediately after the edge that stores word `2**ADDR_WIDTH`.
- Throughput is one word per cycle in each direction, sustained.

## Configuration
- `AXIS_SYNC_FIFO_COUNT_EN` defined:
  - Adds output `count` = write pointer − read pointer, width `ADDR_WIDTH+1`, range 0..`2**ADDR_WIDTH`.
  - `count` updates on the same edges as the pointers.
- `AXIS_SYNC_FIFO_COUNT_EN` undefined: port `count` and its logic are absent. All other behaviour is identical.

## Test plan
- Reset pulse (10 cycles high), then release → `m_axis_tvalid` = 0 throughout. `s_axis_tready` = 0 during reset and 1 from the first edge after release.
- Write 8 words 1..8 with `m_axis_tready` = 0, hold 100 cycles, then set `m_axis_tready` = 1 → outputs 1..8 on consecutive cycles, then `m_axis_tvalid` = 0. Repeat 20-cycle ready/idle loops with no loss or duplication.
- Continuous `m_axis_tready` = 1 while writing 8 words → each word appears on `m_axis_tdata` one cycle after its write. The FIFO never holds more than 1 word.
- Fill with 16 words (0x0000..0x000F) with reads blocked → `s_axis_tready` = 0 after the 16th. A 17th valid word is ignored. Draining yields exactly 0x0000..0x000F.
- When full, assert `s_axis_tvalid` and `m_axis_tready` together → the read occurs and the write does not. The next cycle accepts the write, and 2**ADDR_WIDTH words wrap correctly across the pointer MSB.
- Assert `rst` with 5 words stored → `m_axis_tvalid` drops immediately. After release the FIFO is empty, and with `AXIS_SYNC_FIFO_COUNT_EN` defined `count` = 0 (it read 5 before reset).

Source files
------------

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO, first-word-fall-through, one cycle write-to-read latency.
// Optional occupancy output `count` is enabled by defining AXIS_SYNC_FIFO_COUNT_EN.
module axis_sync_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
`ifdef AXIS_SYNC_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   count
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q;
  logic [ADDR_WIDTH:0]   wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q;
  logic [ADDR_WIDTH:0]   rd_ptr_d;
  logic                  ready_q;
  logic                  empty_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  rd_en_s;

  // Pointer MSB tells a full buffer apart from an empty one when the low bits match.
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign s_axis_tready = ready_q & ~full_s;
  assign m_axis_tvalid = ~empty_s;
  assign m_axis_tdata  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  assign wr_en_s = s_axis_tvalid & s_axis_tready;
  assign rd_en_s = m_axis_tvalid & m_axis_tready;

`ifdef AXIS_SYNC_FIFO_COUNT_EN
  assign count = wr_ptr_q - rd_ptr_q;
`endif

  // Next-state pointer computation.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and ready-flag registers; ready holds off intake until the first edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {(ADDR_WIDTH + 1){1'b0}};
      rd_ptr_q <= {(ADDR_WIDTH + 1){1'b0}};
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= 1'b1;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Randomized and directed bench for axis_sync_fifo against a queue-based reference model.
// Handles both builds, with and without AXIS_SYNC_FIFO_COUNT_EN.
module tb_axis_sync_fifo;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
`ifdef AXIS_SYNC_FIFO_COUNT_EN
  logic [AW:0]   count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q [$];
  bit            model_ready = 1'b0;

  axis_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rst           (rst),
    .clk           (clk),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef AXIS_SYNC_FIFO_COUNT_EN
    ,
    .count         (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a word moves only on a completed handshake; reset empties everything.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      model_ready = 1'b0;
    end else begin
      bit do_wr;
      bit do_rd;
      do_wr = s_axis_tvalid && model_ready && (model_q.size() < DEPTH);
      do_rd = m_axis_tready && (model_q.size() != 0);
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(s_axis_tdata);
      model_ready = 1'b1;
    end
  end

  // Compare the DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
`ifdef AXIS_SYNC_FIFO_COUNT_EN
      check("rst_count", {27'd0, count}, 32'd0);
`endif
    end else begin
      check("tvalid", {31'd0, m_axis_tvalid}, {31'd0, (model_q.size() != 0)});
      check("tready", {31'd0, s_axis_tready},
            {31'd0, (model_ready && (model_q.size() < DEPTH))});
      if (model_q.size() != 0) check("tdata", {16'd0, m_axis_tdata}, {16'd0, model_q[0]});
`ifdef AXIS_SYNC_FIFO_COUNT_EN
      check("count", {27'd0, count}, model_q.size());
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sv, input logic [DW-1:0] sd, input bit mr);
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    m_axis_tready = mr;
  endtask

  initial begin
    int vp;
    int rp;

    // Reset for 10 cycles, then release.
    repeat (10) step();
    check("in_rst_tready", {31'd0, s_axis_tready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_tready_before_edge", {31'd0, s_axis_tready}, 32'd0);
    step();
    check("rel_tready_after_edge", {31'd0, s_axis_tready}, 32'd1);
    check("rel_tvalid", {31'd0, m_axis_tvalid}, 32'd0);

    // Eight words with downstream stalled, long hold, then drain.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    repeat (100) step();
    check("hold_tdata", {16'd0, m_axis_tdata}, 32'd1);
`ifdef AXIS_SYNC_FIFO_COUNT_EN
    check("hold_count", {27'd0, count}, 32'd8);
`endif
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain8_word", {16'd0, m_axis_tdata}, i);
      step();
    end
    check("drain8_empty", {31'd0, m_axis_tvalid}, 32'd0);

    // Pass-through: each word shows up right after its write edge.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(100 + i), 1'b1);
      step();
      check("pass_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      check("pass_tdata", {16'd0, m_axis_tdata}, 100 + i);
    end
    drive(1'b0, '0, 1'b1);
    step();
    check("pass_empty", {31'd0, m_axis_tvalid}, 32'd0);

    // Fill to full, offer a 17th word, drain.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(i), 1'b0);
      step();
    end
    check("full_tready", {31'd0, s_axis_tready}, 32'd0);
    drive(1'b1, 16'hBEEF, 1'b0);
    repeat (3) step();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_drain_word", {16'd0, m_axis_tdata}, i);
      step();
    end
    check("fill_drain_empty", {31'd0, m_axis_tvalid}, 32'd0);

    // Full with simultaneous valid and ready: only the read happens.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(16'h20 + i), 1'b0);
      step();
    end
    drive(1'b1, 16'h0030, 1'b1);
    step();
    check("fullrw_head", {16'd0, m_axis_tdata}, 32'h21);
    check("fullrw_tready", {31'd0, s_axis_tready}, 32'd1);
    drive(1'b1, 16'h0030, 1'b0);
    step();
    check("fullrw_refull", {31'd0, s_axis_tready}, 32'd0);
    drive(1'b0, '0, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("fullrw_drain", {16'd0, m_axis_tdata}, 32'h20 + i);
      step();
    end
    check("fullrw_empty", {31'd0, m_axis_tvalid}, 32'd0);

    // Random traffic in 20-cycle epochs with varying valid/ready density.
    for (int e = 0; e < 150; e++) begin
      vp = $urandom_range(0, 100);
      rp = $urandom_range(0, 100);
      for (int c = 0; c < 20; c++) begin
        drive(($urandom_range(0, 99) < vp), DW'($urandom), ($urandom_range(0, 99) < rp));
        step();
      end
    end

    // Reset with five words stored discards them immediately.
    drive(1'b0, '0, 1'b1);
    repeat (DEPTH + 2) step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(16'h50 + i), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
`ifdef AXIS_SYNC_FIFO_COUNT_EN
    check("pre_rst_count", {27'd0, count}, 32'd5);
`endif
    check("pre_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("async_rst_tready", {31'd0, s_axis_tready}, 32'd0);
`ifdef AXIS_SYNC_FIFO_COUNT_EN
    check("async_rst_count", {27'd0, count}, 32'd0);
`endif
    repeat (3) step();
    rst = 1'b0;
    step();
    check("post_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("post_rst_tready", {31'd0, s_axis_tready}, 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
